// File: rtl/ef_psram_resp_pkg.sv
// Shared types and constants for the QSPI PSRAM responder.
package ef_psram_resp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRData,
        StWData,
        StIgnore
    } state_t;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_EQIO   = 8'h35;
    localparam logic [7:0] CMD_RSTQIO = 8'hF5;

    localparam int unsigned ADDR_NIBBLES = 6;

endpackage

// File: rtl/ef_psram_resp_sync.sv
// Synchronizer for sck/ce_n/din with sck and ce_n edge pulses.
module ef_psram_resp_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] din,
    output logic [3:0] din_s,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_fall,
    output logic       ce_rise
);

    // Bit layout {ce_n, sck, din}; reset looks like an idle, deselected bus.
    localparam logic [5:0] RST_VAL = 6'b10_0000;

    logic [5:0] sync_q [SYNC_STAGES];
    logic       sck_prev_q;
    logic       ce_prev_q;
    logic       sck_s;
    logic       ce_s;
    logic       ce_chg;

    // Synchronizer chain plus one extra sample of sck/ce_n for edge detection.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= RST_VAL;
            sck_prev_q <= 1'b0;
            ce_prev_q  <= 1'b1;
        end else begin
            sync_q[0] <= {ce_n, sck, din};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            sck_prev_q <= sync_q[SYNC_STAGES-1][4];
            ce_prev_q  <= sync_q[SYNC_STAGES-1][5];
        end
    end

    // A ce_n change in the same sample swallows any sck edge.
    always_comb begin
        ce_s     = sync_q[SYNC_STAGES-1][5];
        sck_s    = sync_q[SYNC_STAGES-1][4];
        din_s    = sync_q[SYNC_STAGES-1][3:0];
        ce_chg   = ce_s ^ ce_prev_q;
        sck_rise = sck_s & ~sck_prev_q & ~ce_chg;
        sck_fall = ~sck_s & sck_prev_q & ~ce_chg;
        ce_fall  = ~ce_s & ce_prev_q;
        ce_rise  = ce_s & ~ce_prev_q;
    end

endmodule

// File: rtl/ef_psram_qspi_responder.sv
// QSPI PSRAM device-side responder backed by an internal byte array.
// Optional SPI power-up mode with QPI entry: EF_PSRAM_RESP_QPI_ENTRY_EN.
module ef_psram_qspi_responder
    import ef_psram_resp_pkg::*;
#(
    parameter int unsigned AW           = 10,
    parameter int unsigned DUMMY_CYCLES = 6,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic [3:0] douten
);

    // Shift register only as wide as anything ever read out of it.
    localparam int unsigned SH_W      = (AW > 8) ? AW : 8;
    localparam logic [7:0]  DUMMY_CNT = 8'(DUMMY_CYCLES);

    logic [3:0] din_s;
    logic       sck_rise, sck_fall, ce_fall, ce_rise;

    ef_psram_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .sck      (sck),
        .ce_n     (ce_n),
        .din      (din),
        .din_s    (din_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ce_fall  (ce_fall),
        .ce_rise  (ce_rise)
    );

    logic [7:0]    mem [2**AW];
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [SH_W-1:0] sh_q, sh_d, shifted;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    rsh_q, rsh_d, rsrc, mem_rdata, op;
    logic [3:0]    dout_q, dout_d, douten_q, douten_d;
    logic          rd_q, rd_d, drive, mem_we, quad;
    logic [7:0]    byte_len, addr_len;

`ifdef EF_PSRAM_RESP_QPI_ENTRY_EN
    logic quad_q, quad_d, pend_q, pend_d;
    assign quad = quad_q;
`else
    assign quad = 1'b1;
`endif

    assign mem_rdata = mem[ptr_q];
    assign dout      = dout_q;
    assign douten    = douten_q;

    // Next-state: command/address/data shifting and read-data driving.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        ptr_d    = ptr_q;
        rsh_d    = rsh_q;
        rd_d     = rd_q;
        dout_d   = dout_q;
        douten_d = douten_q;
        mem_we   = 1'b0;
        drive    = 1'b0;
        rsrc     = rsh_q;
`ifdef EF_PSRAM_RESP_QPI_ENTRY_EN
        quad_d   = quad_q;
        pend_d   = pend_q;
`endif
        byte_len = quad ? 8'd2 : 8'd8;
        addr_len = quad ? 8'(ADDR_NIBBLES) : 8'(ADDR_NIBBLES * 4);
        shifted  = quad ? {sh_q[SH_W-5:0], din_s} : {sh_q[SH_W-2:0], din_s[0]};
        op       = shifted[7:0];

        if (ce_rise) begin
            state_d  = StIdle;
            cnt_d    = '0;
            dout_d   = 4'h0;
            douten_d = 4'h0;
`ifdef EF_PSRAM_RESP_QPI_ENTRY_EN
            if (pend_q) quad_d = ~quad_q;
            pend_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ce_fall) begin
                        state_d = StCmd;
                        cnt_d   = '0;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == byte_len) begin
                            cnt_d = '0;
                            if (op == CMD_QREAD) begin
                                rd_d    = 1'b1;
                                state_d = StAddr;
                            end else if (op == CMD_QWRITE || op == CMD_WRITE) begin
                                rd_d    = 1'b0;
                                state_d = StAddr;
                            end else begin
                                state_d = StIgnore;
                            end
`ifdef EF_PSRAM_RESP_QPI_ENTRY_EN
                            // Mode switch takes effect at the end of this access.
                            if ((!quad_q && op == CMD_EQIO) || (quad_q && op == CMD_RSTQIO))
                                pend_d = 1'b1;
`endif
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == addr_len) begin
                            cnt_d   = '0;
                            ptr_d   = shifted[AW-1:0];
                            state_d = rd_q ? StDummy : StWData;
                        end
                    end
                end
                StDummy: begin
                    if (sck_rise && cnt_q != DUMMY_CNT) cnt_d = cnt_q + 8'd1;
                    if (sck_fall && cnt_q == DUMMY_CNT) begin
                        drive   = 1'b1;
                        rsrc    = mem_rdata;
                        cnt_d   = 8'd1;
                        state_d = StRData;
                    end
                end
                StRData: begin
                    if (sck_fall) begin
                        drive = 1'b1;
                        if (cnt_q == byte_len) begin
                            rsrc  = mem_rdata;
                            cnt_d = 8'd1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                            // Last piece of this byte is now on the bus.
                            if (cnt_q + 8'd1 == byte_len) ptr_d = ptr_q + AW'(1);
                        end
                    end
                end
                StWData: begin
                    if (sck_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == byte_len) begin
                            cnt_d  = '0;
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + AW'(1);
                        end
                    end
                end
                StIgnore: douten_d = 4'h0;
                default:  state_d  = StIdle;
            endcase

            if (drive) begin
                if (quad) begin
                    dout_d   = rsrc[7:4];
                    rsh_d    = {rsrc[3:0], 4'h0};
                    douten_d = 4'hF;
                end else begin
                    dout_d   = {2'b00, rsrc[7], 1'b0};
                    rsh_d    = {rsrc[6:0], 1'b0};
                    douten_d = 4'b0010;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sh_q     <= '0;
            ptr_q    <= '0;
            rsh_q    <= '0;
            rd_q     <= 1'b0;
            dout_q   <= 4'h0;
            douten_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            ptr_q    <= ptr_d;
            rsh_q    <= rsh_d;
            rd_q     <= rd_d;
            dout_q   <= dout_d;
            douten_q <= douten_d;
        end
    end

`ifdef EF_PSRAM_RESP_QPI_ENTRY_EN
    // Interface mode: SPI after reset, quad after a completed 0x35.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            quad_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            quad_q <= quad_d;
            pend_q <= pend_d;
        end
    end
`endif

    // Byte array write port; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (mem_we) mem[ptr_q] <= shifted[7:0];
    end

endmodule

// File: tb/tb_ef_psram_qspi_responder.sv
// Scoreboard bench: reads push expected nibbles, a monitor checks each driven nibble.
module tb_ef_psram_qspi_responder;

    localparam int unsigned DUMMY = 6;
    localparam time HALF = 60ns;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic       sck = 1'b0;
    logic       ce_n = 1'b1;
    logic [3:0] din = 4'h0;
    logic [3:0] dout, douten;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    ef_psram_qspi_responder #(.AW(10), .DUMMY_CYCLES(DUMMY), .SYNC_STAGES(2)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .sck     (sck),
        .ce_n    (ce_n),
        .din     (din),
        .dout    (dout),
        .douten  (douten)
    );

    always #5ns HCLK = ~HCLK;

    initial begin
        #5ms;
        $display("FAIL watchdog expired: got timeout, required completion");
        $fatal(1);
    end

    // Monitor: any driven nibble seen by the controller's rising edge must match.
    always @(posedge sck) begin
        if (!ce_n && douten !== 4'h0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_drive: got douten=%h dout=%h, required douten=0",
                         douten, dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ({douten, dout} !== e) begin
                    miscompares++;
                    $display("FAIL read_nibble: got %h_%h, required %h_%h",
                             douten, dout, e[7:4], e[3:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic clk_nib(input logic [3:0] n);
        din = n;
        #HALF sck = 1'b1;
        #HALF sck = 1'b0;
    endtask

    task automatic start(input logic [7:0] op, input logic [23:0] addr);
        ce_n = 1'b0;
        #HALF;
        clk_nib(op[7:4]);
        clk_nib(op[3:0]);
        for (int i = 5; i >= 0; i--) clk_nib(addr[i*4 +: 4]);
    endtask

    task automatic finish_txn();
        #HALF ce_n = 1'b1;
        #(2 * HALF);
    endtask

    task automatic write_bytes(input logic [7:0] op, input logic [23:0] addr,
                               input logic [7:0] d [4], input int n);
        start(op, addr);
        for (int i = 0; i < n; i++) begin
            clk_nib(d[i][7:4]);
            clk_nib(d[i][3:0]);
        end
        finish_txn();
    endtask

    task automatic read_bytes(input logic [23:0] addr, input logic [7:0] d [4], input int n);
        start(8'hEB, addr);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'hF, d[i][7:4]});
            exp_q.push_back({4'hF, d[i][3:0]});
        end
        for (int i = 0; i < int'(DUMMY); i++) begin
            din = 4'h0;
            #HALF sck = 1'b1;
            check("dummy_douten", {4'h0, douten}, 8'h00);
            #HALF sck = 1'b0;
        end
        for (int i = 0; i < 2 * n; i++) clk_nib(4'h0);
        finish_txn();
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        exp_q.delete();
    endtask

    task automatic enter_qpi();
`ifdef EF_PSRAM_RESP_QPI_ENTRY_EN
        logic [7:0] c;
        c = 8'h35;
        ce_n = 1'b0;
        #HALF;
        for (int i = 7; i >= 0; i--) clk_nib({3'b000, c[i]});
        finish_txn();
`endif
    endtask

    initial begin
        logic [7:0] d [4];

        #23ns;
        check("reset_douten", {4'h0, douten}, 8'h00);
        check("reset_dout", {4'h0, dout}, 8'h00);
        HRESETn = 1'b0;
        #50ns;
        enter_qpi();

        d = '{8'hAB, 8'hCD, 8'h12, 8'h34};
        write_bytes(8'h38, 24'h000000, d, 4);
        read_bytes(24'h000000, d, 4);

        d = '{8'h12, 8'h00, 8'h00, 8'h00};
        read_bytes(24'h000002, d, 1);

        d = '{8'h88, 8'h77, 8'h66, 8'h55};
        write_bytes(8'h02, 24'h000064, d, 4);
        read_bytes(24'h000064, d, 2);

        // Upper address bits are ignored.
        d = '{8'hAB, 8'h00, 8'h00, 8'h00};
        read_bytes(24'h000400, d, 1);

        // Wrap from the top of the array to 0.
        d = '{8'h5A, 8'hA5, 8'h00, 8'h00};
        write_bytes(8'h38, 24'h0003FF, d, 2);
        read_bytes(24'h0003FF, d, 2);
        d = '{8'hA5, 8'h00, 8'h00, 8'h00};
        read_bytes(24'h000000, d, 1);

        // Partial write byte is discarded.
        d = '{8'h00, 8'h99, 8'h00, 8'h00};
        write_bytes(8'h38, 24'h000010, d, 2);
        start(8'h38, 24'h000010);
        clk_nib(4'h1);
        clk_nib(4'h2);
        clk_nib(4'hF);
        finish_txn();
        d = '{8'h12, 8'h99, 8'h00, 8'h00};
        read_bytes(24'h000010, d, 2);

        // Unknown opcode: bus stays released.
        ce_n = 1'b0;
        #HALF;
        clk_nib(4'h9);
        clk_nib(4'hF);
        for (int i = 0; i < 10; i++) begin
            din = 4'h0;
            #HALF sck = 1'b1;
            check("ignore_douten", {4'h0, douten}, 8'h00);
            #HALF sck = 1'b0;
        end
        finish_txn();
        d = '{8'h12, 8'h34, 8'h00, 8'h00};
        read_bytes(24'h000002, d, 2);

        // Reset in the middle of read data.
        start(8'hEB, 24'h000000);
        exp_q.push_back(8'hFA);
        exp_q.push_back(8'hF5);
        for (int i = 0; i < int'(DUMMY); i++) clk_nib(4'h0);
        clk_nib(4'h0);
        clk_nib(4'h0);
        #(HALF / 2);
        HRESETn = 1'b1;
        #3ns;
        check("midreset_douten", {4'h0, douten}, 8'h00);
        check("midreset_dout", {4'h0, dout}, 8'h00);
        check("midreset_queue", 8'(exp_q.size()), 8'h00);
        exp_q.delete();
        #20ns HRESETn = 1'b0;
        finish_txn();
        enter_qpi();
        d = '{8'h12, 8'h34, 8'h00, 8'h00};
        read_bytes(24'h000002, d, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ef_psram_qspi_responder.md
Name: ef_psram_qspi_responder

Overview:
Synthesizable QSPI PSRAM device-side responder: the far end of the PSRAM controller's quad-SPI link. It decodes quad-mode commands on sck/ce_n/din and serves reads and writes from an internal byte array. It is used as an on-chip PSRAM stand-in for FPGA bring-up and as a cycle-accurate verification target. It runs on HCLK and oversamples sck, which is treated as asynchronous.

Parameters:
- AW, 10, byte-address width of the internal array (2^AW bytes); the upper address bits are ignored, so addresses wrap modulo 2^AW.
- DUMMY_CYCLES, 6, sck wait cycles between the address and read data for command 0xEB.
- SYNC_STAGES, 2, flops in the sck/ce_n/din synchronizers (minimum 2).

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  reset, asynchronous, active-high; clock HCLK.
- sck  in  1  serial clock from the controller; each phase must last at least SYNC_STAGES+2 HCLK cycles.
- ce_n  in  1  chip enable, active low.
- din  in  4  quad data from the bus, sampled on sck rising edges.
- dout  out  4  quad data to the bus, changed after sck falling edges.
- douten  out  4  output enables; all bits are equal.

Behaviour:
- Reset (asynchronous): state IDLE, dout=0, douten=0, nibble and edge counters cleared. Array contents are not reset.
- sck, ce_n and din pass through SYNC_STAGES flops. Edge detect compares the last two synchronized sck samples.
- A transaction starts on synchronized ce_n falling. ce_n rising in any state forces IDLE with douten=0 on the next HCLK. A partially received write byte is discarded.
- Nibble order is MSB-first everywhere: command, address and data.
- FSM:
  - IDLE: wait for ce_n low, then go to CMD.
  - CMD: 2 rising edges assemble the 8-bit opcode. 0xEB goes to ADDR (read); 0x38 or 0x02 goes to ADDR (write); any other opcode goes to IGNORE.
  - ADDR: 6 rising edges give a 24-bit address; bits [AW-1:0] load the pointer. Reads then go to DUMMY, writes to WDATA.
  - DUMMY: count DUMMY_CYCLES rising edges. On the falling edge after the last one, drive dout=mem[ptr][7:4], assert douten=4'hF and go to RDATA.
  - RDATA: each falling edge alternates the low nibble and then the next byte's high nibble. ptr increments once the low nibble has been driven and wraps 2^AW-1 to 0.
  - WDATA: rising edges alternate between latching the high nibble and committing a byte. On the second (low) nibble, mem[ptr] is written and ptr increments with wrap.
  - IGNORE: douten=0 until ce_n rises.
- Latency: dout and douten update at most SYNC_STAGES+2 HCLK after the sck falling edge.
- If sck and ce_n change in the same synchronized sample, ce_n takes priority and the edge is discarded.
- Reset mid-transfer aborts immediately; the next access must begin with a new ce_n falling edge.

Optional Feature:
EF_PSRAM_RESP_QPI_ENTRY_EN
- Defined: the device powers up in SPI mode. Commands, address and write data arrive serially on din[0], 8 rising edges per byte. Read data is driven on dout[1] with douten=4'b0010.
  - Opcode 0x35 sets quad mode when ce_n rises; 0xF5 received in quad mode returns to SPI mode.
  - Reset returns the device to SPI mode.
- Undefined: the device is always in quad mode; 0x35 and 0xF5 are treated as unknown and go to IGNORE.

Decomposition:
- Package ef_psram_resp_pkg holds: the state enum; the opcode constants CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_WRITE=8'h02, CMD_EQIO=8'h35, CMD_RSTQIO=8'hF5; and the address-nibble count 6.
- One sub-module, ef_psram_resp_sync: a SYNC_STAGES synchronizer plus sck rise/fall pulse generation.

Test Plan:
- Quad write 0x38 at address 0x000000 with bytes AB CD 12 34, then 0xEB read of 4 bytes → AB CD 12 34; douten is 0 through DUMMY_CYCLES and 4'hF on the first data nibble.
- 0xEB read at address 2 of 1 byte → 0x12; with address 0x000064 after writing 88 77 66 55 there → reads 88 77.
- Write 2 bytes at 2^AW-1 (0x3FF) with data 5A A5 → mem[0x3FF]=5A, mem[0x000]=A5; reading from 0x3FF returns 5A A5.
- Write to 0x10 of 0x12 followed by one nibble 0xF, then ce_n rises → mem[0x11] unchanged; the next command decodes cleanly.
- Opcode 0x9F, then 10 sck cycles → douten stays 0; FSM returns to IDLE on ce_n rise.
- HRESETn pulse during RDATA → douten=0 and dout=0 at once; a following 0xEB read returns correct data. With EF_PSRAM_RESP_QPI_ENTRY_EN, serial 0x35 is required first, otherwise a quad write is ignored.
